lifo_fifo_buf: RTL and testbench



---
 rtl/lifo_fifo_buf.sv | 142 ++++++++++++++
 tb/tb_lifo_fifo_buf.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_fifo_buf.sv
// rtl/lifo_fifo_buf.sv - single-clock buffer with run-time FIFO/LIFO mode, occupancy count and thresholds (optional error flags: LIFO_FIFO_ERR_FLAGS_EN)
module lifo_fifo_buf #(
    parameter int DAT_WIDTH = 32,
    parameter int DEPTH     = 64,
    parameter int L         = 6,
    parameter int AF_THRESH = 60,
    parameter int AE_THRESH = 4
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Mode,
    input  logic                 Clr,
    input  logic [DAT_WIDTH-1:0] Datain,
    input  logic                 Wren,
    input  logic                 Rden,
    output logic [DAT_WIDTH-1:0] Dataout,
    output logic                 Dataout_valid,
    output logic                 Full,
    output logic                 Empty,
    output logic                 Almost_full,
    output logic                 Almost_empty,
    output logic [L:0]           Count,
    output logic                 Overflow,
    output logic                 Underflow
);

    localparam int       CW       = L + 1;
    localparam logic [L:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [L:0]   AF_C     = CW'(AF_THRESH);
    localparam logic [L:0]   AE_C     = CW'(AE_THRESH);
    localparam logic [L-1:0] LAST_PTR = L'(DEPTH - 1);

    logic [DAT_WIDTH-1:0] mem [DEPTH];
    logic [L-1:0]         wr_ptr;
    logic [L-1:0]         rd_ptr;
    logic                 fifo_mode;

    logic                 rd_acc;
    logic                 wr_acc;
    logic [L:0]           count_nxt;
    logic [L:0]           lifo_top;
    logic [L-1:0]         wr_addr;
    logic [L-1:0]         rd_addr;
    logic [L-1:0]         wr_ptr_nxt;
    logic [L-1:0]         rd_ptr_nxt;

    // Access acceptance, next occupancy and storage addressing for the active mode.
    // In LIFO mode a simultaneous read/write reads the old top and overwrites that
    // same slot, so the stack depth is unchanged.
    always_comb begin
        rd_acc     = Rden && !Empty;
        wr_acc     = Wren && (!Full || rd_acc);
        lifo_top   = Count - CW'(1);
        count_nxt  = Count;
        if (wr_acc && !rd_acc) begin
            count_nxt = Count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = Count - CW'(1);
        end
        rd_addr    = fifo_mode ? rd_ptr : lifo_top[L-1:0];
        wr_addr    = fifo_mode ? wr_ptr : (rd_acc ? lifo_top[L-1:0] : Count[L-1:0]);
        wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + L'(1);
        rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + L'(1);
    end

    // Storage array write; contents are deliberately left untouched by flush and reset.
    always_ff @(posedge Clk) begin
        if (Rst_n && !Clr && wr_acc) begin
            mem[wr_addr] <= Datain;
        end
    end

    // Pointers, occupancy, registered flags, read data and active mode.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            Count         <= '0;
            Dataout       <= '0;
            Dataout_valid <= 1'b0;
            Full          <= 1'b0;
            Empty         <= 1'b1;
            Almost_full   <= 1'b0;
            Almost_empty  <= 1'b1;
            fifo_mode     <= 1'b1;
        end else if (Clr) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            Count         <= '0;
            Dataout_valid <= 1'b0;
            Full          <= 1'b0;
            Empty         <= 1'b1;
            Almost_full   <= 1'b0;
            Almost_empty  <= 1'b1;
            fifo_mode     <= Mode;
        end else begin
            if (fifo_mode && wr_acc) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (fifo_mode && rd_acc) begin
                rd_ptr <= rd_ptr_nxt;
            end
            if (rd_acc) begin
                Dataout <= mem[rd_addr];
            end
            Dataout_valid <= rd_acc;
            Count         <= count_nxt;
            Full          <= (count_nxt == DEPTH_C);
            Empty         <= (count_nxt == '0);
            Almost_full   <= (count_nxt >= AF_C);
            Almost_empty  <= (count_nxt <= AE_C);
            // Mode requests only take effect while nothing is stored.
            if (Count == '0 && !wr_acc) begin
                fifo_mode <= Mode;
            end
        end
    end

`ifdef LIFO_FIFO_ERR_FLAGS_EN
    // Sticky error flags for rejected writes (full) and rejected reads (empty).
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else if (Clr) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (Wren && !wr_acc) begin
                Overflow <= 1'b1;
            end
            if (Rden && Empty) begin
                Underflow <= 1'b1;
            end
        end
    end
`else
    assign Overflow  = 1'b0;
    assign Underflow = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_fifo_buf.sv
// tb/tb_lifo_fifo_buf.sv - scoreboard bench for lifo_fifo_buf (DEPTH=8, DAT_WIDTH=8, AF=6, AE=1)
module tb_lifo_fifo_buf;

    localparam int DW  = 8;
    localparam int DEP = 8;
    localparam int LW  = 3;
    localparam int AF  = 6;
    localparam int AE  = 1;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          Mode;
    logic          Clr;
    logic [DW-1:0] Datain;
    logic          Wren;
    logic          Rden;
    logic [DW-1:0] Dataout;
    logic          Dataout_valid;
    logic          Full;
    logic          Empty;
    logic          Almost_full;
    logic          Almost_empty;
    logic [LW:0]   Count;
    logic          Overflow;
    logic          Underflow;

    always #5 Clk = ~Clk;

    lifo_fifo_buf #(
        .DAT_WIDTH (DW),
        .DEPTH     (DEP),
        .L         (LW),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Mode          (Mode),
        .Clr           (Clr),
        .Datain        (Datain),
        .Wren          (Wren),
        .Rden          (Rden),
        .Dataout       (Dataout),
        .Dataout_valid (Dataout_valid),
        .Full          (Full),
        .Empty         (Empty),
        .Almost_full   (Almost_full),
        .Almost_empty  (Almost_empty),
        .Count         (Count),
        .Overflow      (Overflow),
        .Underflow     (Underflow)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] exp_q[$];
    logic          m_fifo;
    logic          m_ovf;
    logic          m_unf;
    logic          mode;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_fifo = 1'b1;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic check_flags(input string tag);
        int  c;
        logic eo;
        logic eu;
        c = m_q.size();
`ifdef LIFO_FIFO_ERR_FLAGS_EN
        eo = m_ovf;
        eu = m_unf;
`else
        eo = 1'b0;
        eu = 1'b0;
`endif
        check({tag, ":count"},  32'(Count),        32'(c));
        check({tag, ":empty"},  32'(Empty),        32'(c == 0));
        check({tag, ":full"},   32'(Full),         32'(c == DEP));
        check({tag, ":afull"},  32'(Almost_full),  32'(c >= AF));
        check({tag, ":aempty"}, 32'(Almost_empty), 32'(c <= AE));
        check({tag, ":ovf"},    32'(Overflow),     32'(eo));
        check({tag, ":unf"},    32'(Underflow),    32'(eu));
    endtask

    task automatic check_reset(input string tag);
        check({tag, ":count"},  32'(Count),         32'(0));
        check({tag, ":dout"},   32'(Dataout),       32'(0));
        check({tag, ":valid"},  32'(Dataout_valid), 32'(0));
        check({tag, ":empty"},  32'(Empty),         32'(1));
        check({tag, ":full"},   32'(Full),          32'(0));
        check({tag, ":afull"},  32'(Almost_full),   32'(0));
        check({tag, ":aempty"}, 32'(Almost_empty),  32'(1));
        check({tag, ":ovf"},    32'(Overflow),      32'(0));
        check({tag, ":unf"},    32'(Underflow),     32'(0));
    endtask

    // One clock of stimulus: model the expected outcome, drive, then compare after the edge.
    task automatic step(input logic wr, input logic rd, input logic [DW-1:0] din, input logic clr);
        int            c;
        logic          rd_ok;
        logic          wr_ok;
        logic [DW-1:0] w;
        c     = m_q.size();
        rd_ok = 1'b0;
        wr_ok = 1'b0;
        if (clr) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_fifo = mode;
        end else begin
            rd_ok = rd && (c > 0);
            wr_ok = wr && ((c < DEP) || rd_ok);
            if (rd_ok) begin
                w = m_fifo ? m_q.pop_front() : m_q.pop_back();
                exp_q.push_back(w);
            end
            if (wr_ok) m_q.push_back(din);
            if (wr && !wr_ok) m_ovf = 1'b1;
            if (rd && c == 0) m_unf = 1'b1;
            if (c == 0 && !wr_ok) m_fifo = mode;
        end
        Wren   = wr;
        Rden   = rd;
        Datain = din;
        Clr    = clr;
        Mode   = mode;
        @(posedge Clk);
        #1;
        Wren = 1'b0;
        Rden = 1'b0;
        Clr  = 1'b0;
        check("valid", 32'(Dataout_valid), 32'(rd_ok));
        if (Dataout_valid) begin
            if (exp_q.size() == 0) check("unexpected_out", 32'(1), 32'(0));
            else                   check("dataout", 32'(Dataout), 32'(exp_q.pop_front()));
        end
        check_flags("step");
    endtask

    initial begin
        Rst_n  = 1'b0;
        Mode   = 1'b1;
        Clr    = 1'b0;
        Datain = '0;
        Wren   = 1'b0;
        Rden   = 1'b0;
        mode   = 1'b1;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_reset("reset");
        Rst_n = 1'b1;

        // FIFO fill and drain
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // LIFO ordering and simultaneous read/write on the stack top
        mode = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'hA1, 1'b0);
        step(1'b1, 1'b0, 8'hA2, 1'b0);
        step(1'b1, 1'b0, 8'hA3, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'hC1, 1'b0);
        step(1'b1, 1'b0, 8'hC2, 1'b0);
        step(1'b1, 1'b1, 8'hB0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);

        // Full FIFO: write+read accepted, write alone rejected
        mode = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
        step(1'b1, 1'b1, 8'h40, 1'b0);
        step(1'b1, 1'b0, 8'h41, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Empty: rejected read, then write+read with no bypass
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);

        // FIFO wrap with a mode request while data is held
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) mode = 1'b0;
            step(1'b1, 1'b0, 8'(8'h21 + i), 1'b0);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        mode = 1'b1;

        // Flush with Count=5
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b1);

        // Random mix of modes, accesses and flushes
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), ($urandom_range(0, 40) == 0));
        end

        // Asynchronous reset in the middle of a write burst
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
        Wren   = 1'b1;
        Datain = 8'h93;
        #3;
        Rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        model_reset();
        @(posedge Clk);
        #1;
        Wren = 1'b0;
        check_reset("held_reset");
        Rst_n = 1'b1;
        mode  = 1'b1;
        step(1'b1, 1'b0, 8'hE1, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
